// File: rtl/uart_tx_engine.sv
// Serial transmit engine: one holding register, an 11-bit frame shifter and a
// programmable bit-time counter; 7/8 data bits with optional even/odd parity.
module uart_tx_engine #(
    parameter int BAUD_W = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              EIGHT,
    input  logic              PEN,
    input  logic              OHEL,
    input  logic [BAUD_W-1:0] K,
    input  logic              LOAD,
    input  logic [7:0]        DATA,
    output logic              TX,
    output logic              TXRDY
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SEND
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [7:0]        hold;
    logic [10:0]       shifter;
    logic [BAUD_W-1:0] bt_cnt;
    logic [3:0]        bit_cnt;
    logic              doit;
    logic              btu;
    logic              done;
    logic              accept;
    logic              parity;
    logic              b9;
    logic              b10;

    assign TXRDY  = (state == S_IDLE);
    assign doit   = (state == S_SEND);
    assign accept = TXRDY && LOAD;
    assign btu    = doit && (bt_cnt == K);
    assign done   = btu && (bit_cnt == 4'd10);
    assign TX     = shifter[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (LOAD) state_next = S_LOAD;
            S_LOAD:  state_next = S_SEND;
            S_SEND:  if (done) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign parity = (^hold[6:0]) ^ (EIGHT & hold[7]) ^ OHEL;

    // NOTE: every output of a combinational block gets a default before the
    // case, so no path through it can leave a value held (a latch).
    always_comb begin
        b10 = 1'b1;
        b9  = 1'b1;
        case ({EIGHT, PEN})
            2'b00:   begin b10 = 1'b1;   b9 = 1'b1;    end
            2'b01:   begin b10 = 1'b1;   b9 = parity;  end
            2'b10:   begin b10 = 1'b1;   b9 = hold[7]; end
            default: begin b10 = parity; b9 = hold[7]; end
        endcase
    end

    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold    <= '0;
            shifter <= '1;
            bt_cnt  <= '0;
            bit_cnt <= '0;
        end else begin
            if (accept) hold <= DATA;

            // Frame word {b10,b9,D[6:0],0,1}: its bit 0 is the idle level already
            // on the line, so the load also performs the first shift.
            if (state == S_LOAD) begin
                shifter <= {1'b1, b10, b9, hold[6:0], 1'b0};
            end else if (btu) begin
                shifter <= {1'b1, shifter[10:1]};
            end

            if (!doit || btu) bt_cnt <= '0;
            else              bt_cnt <= bt_cnt + BAUD_W'(1);

            if (!doit)    bit_cnt <= '0;
            else if (btu) bit_cnt <= bit_cnt + 4'd1;
        end
    end

endmodule

// File: doc/uart_tx_engine.md
UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 SHALL have parameter BAUD_W, default 19, width of the bit-time count K.
REQ-002 SHALL have port clk, input, 1: system clock; all logic on rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port EIGHT, input, 1: 1 = eight data bits, 0 = seven.
REQ-005 SHALL have port PEN, input, 1: parity enable.
REQ-006 SHALL have port OHEL, input, 1: 0 = even parity, 1 = odd parity.
REQ-007 SHALL have port K, input, BAUD_W: bit-time count; one bit lasts K+1 clocks.
REQ-008 SHALL have port LOAD, input, 1: one-cycle write strobe for DATA.
REQ-009 SHALL have port DATA, input, 8: byte to transmit.
REQ-010 SHALL have port TX, output, 1: serial line, idle high.
REQ-011 SHALL have port TXRDY, output, 1: 1 = ready to accept LOAD.

Function
REQ-012 SHALL latch DATA into a holding register on the cycle LOAD=1 and TXRDY=1; TXRDY SHALL be 0 from the next cycle.
REQ-013 SHALL ignore LOAD while TXRDY=0; the holding register and frame in progress SHALL be unaffected.
REQ-014 SHALL load an 11-bit shift register one cycle after the accepted LOAD. The register SHALL hold {b10, b9, D[6:0], 0, 1}, and TX SHALL equal shifter bit 0.
REQ-015 SHALL select b10,b9 by {EIGHT,PEN}:
- 00 -> 1,1
- 01 -> 1,P
- 10 -> 1,D[7]
- 11 -> P,D[7]
REQ-016 SHALL compute P as the XOR of D[6:0], including D[7] only when EIGHT=1, then inverted when OHEL=1.
REQ-017 SHALL set DOIT to 1 in the shifter-load cycle and keep it 1 until DONE.
- While DOIT=1, the bit-time counter SHALL increment each clock.
- BTU SHALL assert when the counter equals K, and the counter SHALL clear on BTU.
- When DOIT=0, the counter SHALL be held at 0.
REQ-018 SHALL right-shift the shifter on BTU, filling the top bit with 1. TX sequence: idle 1, then start 0 for K+1 clocks, then D0..D6, b9, b10, each for K+1 clocks.
REQ-019 SHALL count BTUs with a 4-bit bit counter. It SHALL clear when DOIT=0, and DONE SHALL assert on the BTU taking the count to 11.
REQ-020 On DONE, SHALL clear DOIT, set TX to 1 and set TXRDY to 1 on the next cycle. A new LOAD SHALL be accepted that same cycle.
REQ-021 SHALL give a LOAD-to-TX-falling latency of exactly 2 clocks, and a frame length of 11*(K+1) clocks regardless of mode.
REQ-022 SHALL sample EIGHT, PEN, OHEL and the holding register only in the shifter-load cycle; changes later in the frame SHALL not alter the frame.
REQ-023 SHALL use K continuously; a K change mid-frame is unsupported, and software SHALL not change K while TXRDY=0.
REQ-024 SHALL support K=0, giving a one-clock bit time with BTU every cycle while DOIT=1.
REQ-025 SHALL never drive TX low except during start or data/parity bits of a frame; after any DONE or reset, TX SHALL be 1.

Reset
REQ-026 With reset=1 at a rising edge, SHALL set on the next cycle:
- TX=1, TXRDY=1, DOIT=0
- shifter all ones
- bit and bit-time counters 0
- holding register 0
REQ-027 Reset SHALL take priority over LOAD in the same cycle. A frame in progress SHALL be aborted, with TX=1 the next cycle.

Verification
REQ-028 With K=3, EIGHT=1, PEN=0 and LOAD DATA=0x55 at cycle 0, TX SHALL be low at cycle 2. Bits SHALL be 0,1,0,1,0,1,0,1,0,1,1, 4 clocks each, and TXRDY SHALL be 1 at cycle 46.
REQ-029 With K=1, EIGHT=1, PEN=1, OHEL=0 and DATA=0x03, P SHALL be 0. With OHEL=1, the bit-10 slot SHALL be 1.
REQ-030 With K=1, EIGHT=0, PEN=1, OHEL=0 and DATA=0x81, D[7] SHALL be ignored and P=1. Bit 9 SHALL be 1 and bit 10 SHALL be 1.
REQ-031 A second LOAD DATA=0xAA mid-frame with DATA=0x0F SHALL be ignored. The 0x0F frame SHALL complete unchanged, and a LOAD 0xAA on the first TXRDY=1 cycle SHALL start the next frame 2 clocks later.
REQ-032 With K=2 and reset asserted for one cycle at clock 10 of a frame, TX SHALL be 1 and TXRDY SHALL be 1 on the following cycle, and a LOAD one cycle later SHALL transmit a correct frame.
REQ-033 With K=0, EIGHT=0, PEN=0 and DATA=0x7F, TX SHALL be 0,1,1,1,1,1,1,1,1,1,1 on consecutive clocks, and TXRDY SHALL be 1 at cycle 13.
